// File: rtl/fsk_demod_ctrl_if.sv
// Handshake bundle between the FSK demod controller, the ADC sample stream,
// the symbol correlator and the downstream word consumer.
interface fsk_demod_ctrl_if;
    logic                sample_en;
    logic signed [17:0]  adc_in_sin;
    logic                win_active;
    logic                win_start;
    logic                corr_start;
    logic                corr_done;
    logic [2:0]          corr_sym;
    logic                corr_hit;
    logic [23:0]         word_out;
    logic                word_valid;
    logic                word_ready;
    logic                sync_locked;
    logic                overflow;
    logic                timeout_err;

    modport master (
        input  sample_en, adc_in_sin, corr_done, corr_sym, corr_hit, word_ready,
        output win_active, win_start, corr_start, word_out, word_valid,
               sync_locked, overflow, timeout_err
    );

    modport slave (
        output sample_en, adc_in_sin, corr_done, corr_sym, corr_hit, word_ready,
        input  win_active, win_start, corr_start, word_out, word_valid,
               sync_locked, overflow, timeout_err
    );
endinterface

// File: rtl/fsk_demod_ctrl.sv
// FSK demod controller: sync hunt, symbol-window sequencing and 8-symbol word assembly.
// Optional macro FSK_DEMOD_CTRL_LOSS_DETECT_EN returns to hunt after LOSS_LIMIT consecutive misses.
module fsk_demod_ctrl #(
    parameter int N                   = 99,
    parameter int SYNC_THRESHOLD      = 1,
    parameter int SYNC_COUNT_REQUIRED = 8,
    parameter int DONE_TIMEOUT        = 255,
    parameter int LOSS_LIMIT          = 4
) (
    input  logic             clk,
    input  logic             reset,
    fsk_demod_ctrl_if.master bus
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = $clog2(SYNC_COUNT_REQUIRED + 1);
    localparam int TW = $clog2(DONE_TIMEOUT + 1);
    localparam logic signed [17:0] THRESH   = 18'(SYNC_THRESHOLD);
    localparam logic [SW-1:0]      SMP_LAST = SW'(N - 1);
    localparam logic [RW-1:0]      RUN_LAST = RW'(SYNC_COUNT_REQUIRED - 1);
    localparam logic [TW-1:0]      TMO_LAST = TW'(DONE_TIMEOUT - 1);

    if (N < 2 || SYNC_COUNT_REQUIRED < 1 || DONE_TIMEOUT < 2 || LOSS_LIMIT < 1) begin : g_param_check
        $error("fsk_demod_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {HUNT, COLLECT, WAIT_CORR} state_t;
    state_t state, state_next;

    logic [RW-1:0] run_cnt;
    logic [SW-1:0] smp_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]    sym_cnt;
    logic [23:0]   part_word;
    logic [23:0]   next_word;
    logic          adc_gt, sync_hit, win_last, sym_take, word_done, tmo_fire, abort;

`ifdef FSK_DEMOD_CTRL_LOSS_DETECT_EN
    localparam int LW = $clog2(LOSS_LIMIT + 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_LIMIT - 1);
    logic [LW-1:0] loss_cnt;
`endif

    assign adc_gt          = (bus.adc_in_sin > THRESH);
    assign bus.win_active  = (state == COLLECT);
    assign bus.win_start   = bus.sample_en && (state == COLLECT) && (smp_cnt == '0);
    assign bus.sync_locked = (state != HUNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= HUNT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        sync_hit   = 1'b0;
        win_last   = 1'b0;
        sym_take   = 1'b0;
        word_done  = 1'b0;
        tmo_fire   = 1'b0;
        abort      = 1'b0;
        next_word  = part_word;
        for (int i = 0; i < 8; i++) begin
            if (sym_cnt == 3'(i)) next_word[3*i +: 3] = bus.corr_sym;
        end
        unique case (state)
            HUNT: begin
                if (bus.sample_en && adc_gt && run_cnt == RUN_LAST) begin
                    sync_hit   = 1'b1;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.sample_en && smp_cnt == SMP_LAST) begin
                    win_last   = 1'b1;
                    state_next = WAIT_CORR;
                end
            end
            WAIT_CORR: begin
                // corr_done wins over a timeout landing on the same edge
                if (bus.corr_done) begin
                    state_next = COLLECT;
                    if (bus.corr_hit) begin
                        sym_take  = 1'b1;
                        word_done = (sym_cnt == 3'd7);
                    end
`ifdef FSK_DEMOD_CTRL_LOSS_DETECT_EN
                    else if (loss_cnt == LOSS_LAST) begin
                        abort      = 1'b1;
                        state_next = HUNT;
                    end
`endif
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_fire   = 1'b1;
                    abort      = 1'b1;
                    state_next = HUNT;
                end
            end
            default: state_next = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt         <= '0;
            smp_cnt         <= '0;
            tmo_cnt         <= '0;
            sym_cnt         <= '0;
            part_word       <= '0;
            bus.word_out    <= '0;
            bus.word_valid  <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.corr_start  <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.corr_start  <= win_last;
            bus.timeout_err <= tmo_fire;

            if (state != HUNT)      run_cnt <= '0;
            else if (bus.sample_en) run_cnt <= (adc_gt && !sync_hit) ? run_cnt + 1'b1 : '0;

            if (sync_hit || win_last)                  smp_cnt <= '0;
            else if (state == COLLECT && bus.sample_en) smp_cnt <= smp_cnt + 1'b1;

            tmo_cnt <= (state == WAIT_CORR && state_next == WAIT_CORR) ? tmo_cnt + 1'b1 : '0;

            if (sync_hit || abort || word_done) begin
                sym_cnt   <= '0;
                part_word <= '0;
            end else if (sym_take) begin
                sym_cnt   <= sym_cnt + 1'b1;
                part_word <= next_word;
            end

            // A completed word may replace the held one only when it leaves this edge
            if (word_done && (!bus.word_valid || bus.word_ready)) begin
                bus.word_out   <= next_word;
                bus.word_valid <= 1'b1;
            end else begin
                if (word_done)      bus.overflow   <= 1'b1;
                if (bus.word_ready) bus.word_valid <= 1'b0;
            end
        end
    end

`ifdef FSK_DEMOD_CTRL_LOSS_DETECT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                   loss_cnt <= '0;
        else if (sync_hit || sym_take || abort)       loss_cnt <= '0;
        else if (state == WAIT_CORR && bus.corr_done) loss_cnt <= loss_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fsk_demod_ctrl.sv
// Directed bench for fsk_demod_ctrl: hunt, windowing, word assembly, overflow,
// timeout, reset abort and (with FSK_DEMOD_CTRL_LOSS_DETECT_EN) loss of sync.
module tb_fsk_demod_ctrl;
    localparam int N = 99;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    fsk_demod_ctrl_if bus();

    fsk_demod_ctrl #(
        .N(N), .SYNC_THRESHOLD(1), .SYNC_COUNT_REQUIRED(8), .DONE_TIMEOUT(255), .LOSS_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input logic signed [17:0] v);
        bus.sample_en  = 1'b1;
        bus.adc_in_sin = v;
        tick();
        bus.sample_en  = 1'b0;
    endtask

    task automatic hunt_run(input int cnt, input logic signed [17:0] v);
        for (int i = 0; i < cnt; i++) samp(v);
    endtask

    task automatic window();
        int ws = 0;
        for (int i = 0; i < N; i++) begin
            bus.sample_en  = 1'b1;
            bus.adc_in_sin = 18'(i);
            #1;
            if (bus.win_start === 1'b1) ws++;
            @(posedge clk);
            #1;
        end
        bus.sample_en = 1'b0;
        chk("win_start_count", ws, 32'd1);
        chk("corr_start_pulse", 32'(bus.corr_start), 32'd1);
        chk("win_active_wait", 32'(bus.win_active), 32'd0);
    endtask

    task automatic corr(input logic [2:0] s, input logic h);
        bus.corr_done = 1'b1;
        bus.corr_sym  = s;
        bus.corr_hit  = h;
        tick();
        bus.corr_done = 1'b0;
        bus.corr_hit  = 1'b0;
    endtask

    task automatic send_word(input bit rev, input bit ready_last);
        for (int k = 0; k < 8; k++) begin
            window();
            if (k == 7 && ready_last) bus.word_ready = 1'b1;
            corr(rev ? 3'(7 - k) : 3'(k), 1'b1);
            bus.word_ready = 1'b0;
        end
    endtask

    task automatic wait_ticks(input int cnt);
        for (int i = 0; i < cnt; i++) tick();
    endtask

    initial begin
        bus.sample_en  = 1'b0;
        bus.adc_in_sin = '0;
        bus.corr_done  = 1'b0;
        bus.corr_sym   = '0;
        bus.corr_hit   = 1'b0;
        bus.word_ready = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sync_locked", 32'(bus.sync_locked), 32'd0);
        chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
        chk("rst_word_out", 32'(bus.word_out), 32'd0);
        chk("rst_win_active", 32'(bus.win_active), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        reset = 1'b1;
        tick();

        // hunt: a broken run restarts, idle cycles hold the count
        hunt_run(7, 18'sd5);
        chk("hunt_after_7", 32'(bus.sync_locked), 32'd0);
        samp(18'sd0);
        hunt_run(4, 18'sd5);
        wait_ticks(3);
        hunt_run(3, 18'sd5);
        chk("hunt_after_7_again", 32'(bus.sync_locked), 32'd0);
        samp(18'sd5);
        chk("hunt_locked", 32'(bus.sync_locked), 32'd1);
        chk("collect_win_active", 32'(bus.win_active), 32'd1);

        // stray corr_done in COLLECT, then first window and an ignored sample
        corr(3'd6, 1'b1);
        window();
        bus.sample_en = 1'b1;
        #1;
        chk("no_win_start_in_wait", 32'(bus.win_start), 32'd0);
        tick();
        bus.sample_en = 1'b0;
        chk("corr_start_one_cycle", 32'(bus.corr_start), 32'd0);
        chk("win_active_still_0", 32'(bus.win_active), 32'd0);
        corr(3'd0, 1'b1);
        chk("back_to_collect", 32'(bus.win_active), 32'd1);
        for (int k = 1; k < 8; k++) begin
            if (k == 4) begin
                window();
                corr(3'd5, 1'b0);
                chk("nohit_stays_locked", 32'(bus.sync_locked), 32'd1);
            end
            window();
            corr(3'(k), 1'b1);
        end
        chk("word_0to7", 32'(bus.word_out), 32'h00FAC688);
        chk("word_valid_set", 32'(bus.word_valid), 32'd1);
        wait_ticks(3);
        chk("word_valid_held", 32'(bus.word_valid), 32'd1);

        // second word while the first is held -> dropped
        send_word(1'b1, 1'b0);
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        chk("ovf_word_kept", 32'(bus.word_out), 32'h00FAC688);
        bus.word_ready = 1'b1;
        tick();
        bus.word_ready = 1'b0;
        chk("accept_clears_valid", 32'(bus.word_valid), 32'd0);

        // reset mid-word and mid-wait
        window();
        corr(3'd3, 1'b1);
        window();
        reset = 1'b0;
        #2;
        chk("arst_sync_locked", 32'(bus.sync_locked), 32'd0);
        chk("arst_overflow", 32'(bus.overflow), 32'd0);
        chk("arst_corr_start", 32'(bus.corr_start), 32'd0);
        chk("arst_word_out", 32'(bus.word_out), 32'd0);
        wait_ticks(2);
        reset = 1'b1;
        tick();

        // word completing on the same edge as a transfer
        hunt_run(8, 18'sd5);
        send_word(1'b0, 1'b0);
        chk("word_a", 32'(bus.word_out), 32'h00FAC688);
        send_word(1'b1, 1'b1);
        chk("word_b_loaded", 32'(bus.word_out), 32'h00053977);
        chk("word_b_valid", 32'(bus.word_valid), 32'd1);
        chk("word_b_no_ovf", 32'(bus.overflow), 32'd0);

        // timeout with a word pending
        window();
        wait_ticks(254);
        chk("tmo_not_yet", 32'(bus.timeout_err), 32'd0);
        chk("tmo_still_locked", 32'(bus.sync_locked), 32'd1);
        tick();
        chk("tmo_pulse", 32'(bus.timeout_err), 32'd1);
        chk("tmo_unlocked", 32'(bus.sync_locked), 32'd0);
        chk("tmo_word_kept", 32'(bus.word_out), 32'h00053977);
        chk("tmo_valid_kept", 32'(bus.word_valid), 32'd1);
        tick();
        chk("tmo_pulse_end", 32'(bus.timeout_err), 32'd0);

        // threshold is strict and signed
        hunt_run(7, 18'sd5);
        samp(18'sd1);
        hunt_run(7, 18'sd5);
        chk("thresh_equal_clears", 32'(bus.sync_locked), 32'd0);
        samp(-18'sd3);
        hunt_run(7, 18'sd5);
        chk("thresh_negative_clears", 32'(bus.sync_locked), 32'd0);
        samp(18'sd5);
        chk("relocked", 32'(bus.sync_locked), 32'd1);

        // corr_done on the timeout edge wins
        window();
        wait_ticks(254);
        corr(3'd2, 1'b1);
        chk("prio_no_tmo", 32'(bus.timeout_err), 32'd0);
        chk("prio_locked", 32'(bus.sync_locked), 32'd1);
        chk("prio_collect", 32'(bus.win_active), 32'd1);
        bus.word_ready = 1'b1;
        tick();
        bus.word_ready = 1'b0;
        chk("late_accept", 32'(bus.word_valid), 32'd0);

        // consecutive misses
        for (int m = 0; m < 3; m++) begin
            window();
            corr(3'd1, 1'b0);
        end
        chk("miss3_locked", 32'(bus.sync_locked), 32'd1);
        window();
        corr(3'd1, 1'b0);
`ifdef FSK_DEMOD_CTRL_LOSS_DETECT_EN
        chk("miss4_loss", 32'(bus.sync_locked), 32'd0);
`else
        chk("miss4_locked", 32'(bus.sync_locked), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fsk_demod_ctrl.md
FSK_DEMOD_CTRL -- requirements
Module: fsk_demod_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  N, 99, samples per symbol window.
  SYNC_THRESHOLD, 1, signed level adc_in_sin must exceed during sync hunt.
  SYNC_COUNT_REQUIRED, 8, consecutive qualifying samples that declare sync.
  DONE_TIMEOUT, 255, maximum clocks spent waiting for corr_done.
  LOSS_LIMIT, 4, consecutive no-hit symbols that declare loss (REQ-020 only).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk, in, 1, single clock; all state updates on its rising edge.
  reset, in, 1, asynchronous, active-low reset.
  sample_en, in, 1, marks the cycle carrying a valid ADC sample.
  adc_in_sin, in, 18 signed, I sample, used for sync hunt.
  win_active, out, 1, correlator captures the sample on sample_en && win_active.
  win_start, out, 1, one-cycle pulse on the first sample of each window.
  corr_start, out, 1, one-cycle pulse requesting correlation of the captured window.
  corr_done, in, 1, one-cycle pulse from the correlator: result valid.
  corr_sym, in, 3, symbol index 0-7 chosen by the correlator.
  corr_hit, in, 1, peak energy exceeded the correlator threshold.
  word_out, out, 24, eight packed symbols; first-received symbol in bits [2:0].
  word_valid, out, 1, word_out is valid; held until accepted.
  word_ready, in, 1, downstream accepts word_out.
  sync_locked, out, 1, high in every state except HUNT.
  overflow, out, 1, sticky; a completed word was dropped.
  timeout_err, out, 1, one-cycle pulse when the correlator timeout fires.

Function
REQ-003 SHALL implement states HUNT, COLLECT and WAIT_CORR; all events are evaluated only on clk edges.
REQ-004 HUNT: on each sample_en cycle, if adc_in_sin > SYNC_THRESHOLD (signed compare) the run counter SHALL increment, otherwise it SHALL clear; cycles without sample_en SHALL leave it unchanged.
REQ-005 When the increment makes run count equal SYNC_COUNT_REQUIRED, the next state SHALL be COLLECT, with the run counter, sample counter, symbol counter and partial word cleared.
REQ-006 COLLECT: win_active SHALL be 1; the sample counter SHALL count sample_en cycles from 0 to N-1; win_start SHALL equal sample_en && (count == 0).
REQ-007 On the sample_en cycle where count == N-1, the sample counter SHALL wrap to 0, the next state SHALL be WAIT_CORR, and corr_start SHALL pulse high in the first cycle of WAIT_CORR.
REQ-008 WAIT_CORR: win_active SHALL be 0; samples arriving in this state SHALL be ignored; the timeout counter SHALL increment every clock from 0.
REQ-009 A corr_done received in HUNT or COLLECT SHALL be ignored.
REQ-010 On corr_done with corr_hit=1, corr_sym SHALL be written to bits [3k+2:3k] of the partial word, where k is the symbol count; k SHALL then increment; the next state SHALL be COLLECT.
REQ-011 On corr_done with corr_hit=0, the symbol SHALL be discarded, k SHALL be unchanged, and the next state SHALL be COLLECT.
REQ-012 When k reaches 8, word_out SHALL load the full word, word_valid SHALL be set, and k and the partial word SHALL clear, all in the same edge as the eighth hit.
REQ-013 A transfer SHALL occur when word_valid && word_ready; after a transfer with no new word loading in the same edge, word_valid SHALL clear.
REQ-014 If a word completes while word_valid=1 and word_ready=0, the new word SHALL be dropped, word_out SHALL be unchanged and overflow SHALL set.
REQ-015 If a word completes in the same cycle as a transfer, the new word SHALL load, word_valid SHALL stay 1, and no overflow SHALL be raised.
REQ-016 If the timeout counter reaches DONE_TIMEOUT without corr_done, timeout_err SHALL pulse for one cycle and the next state SHALL be HUNT, with the partial word and k cleared.
REQ-017 corr_done arriving on the same edge the timeout fires SHALL take priority, and no timeout SHALL be signalled.
REQ-018 A pending word_valid/word_out SHALL survive the HUNT re-entry and SHALL remain until accepted.

Reset
REQ-019 While reset=0, outputs SHALL be asynchronously forced to: state HUNT; all counters 0; word_out 0; word_valid, win_active, win_start, corr_start, sync_locked, overflow and timeout_err all 0. Reset asserted mid-window or mid-wait SHALL abort with no word emitted.

Configuration
REQ-020 Macro FSK_DEMOD_CTRL_LOSS_DETECT_EN: when defined, LOSS_LIMIT consecutive corr_hit=0 results SHALL force HUNT and clear the partial word, and any hit SHALL clear the loss count; when undefined, no-hit results SHALL never leave sync, and the loss counter SHALL not exist.

Verification
REQ-021 Bench SHALL cover, one scenario per line: stimulus -> required response.
  7 samples of 5 then 0, followed by 8 samples of 5 -> stays in HUNT after the 7, enters COLLECT after the 8th; sync_locked=1.
  Locked, 99 sample_en -> one win_start, corr_start pulses 1 cycle after the 99th sample; win_active=0 until corr_done.
  Eight corr_done hits with syms 0..7 -> word_out=24'hFAC688, word_valid=1 until word_ready.
  Word held with word_ready=0 and a second word completes -> overflow=1, word_out unchanged; repeat with word_ready=1 on that cycle -> no overflow.
  No corr_done for 255 clocks -> timeout_err pulse, sync_locked=0; with the macro defined, 4 no-hit results -> HUNT.
